data_cache: RTL and testbench

- Direct-mapped, write-through, one-word-per-line data cache between the 16-bit processor memory port and the synchronous data BRAM (port B).
- Exposes a registered `hit` indicator for the board test harness.
- Single clock domain (processor clock).
- BRAM read latency is fixed at one cycle.

---
 rtl/data_cache_if.sv | 32 +++
 rtl/data_cache.sv | 123 ++++++++++++
 tb/tb_data_cache.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Processor-side and BRAM port-B signals of the data cache, bundled for port connection.
// The master side drives the request, flush and BRAM read data; the slave side is the cache.
interface data_cache_if #(
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              flush;
  logic              hit;
  logic              mem_en;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid, hit,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_rvalid, hit,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, one-word-per-line data cache in front of a
// single-cycle-latency data BRAM; reads allocate on miss, writes never allocate.
module data_cache #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned DATA_W     = 16
) (
  input  logic        clk_100,
  input  logic        rst_n,
  data_cache_if.slave bus
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 16 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_W-1:0]     data_q [LINES];

  logic [INDEX_BITS-1:0] miss_idx_q;
  logic [TAG_W-1:0]      miss_tag_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rvalid_q;
  logic                  hit_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_f;
  logic                  lookup_hit;
  logic                  ready;
  logic                  accept;
  logic                  mem_en;
  logic                  mem_we;

  assign idx        = bus.cpu_addr[INDEX_BITS-1:0];
  assign tag_f      = bus.cpu_addr[15:INDEX_BITS];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag_f);
  assign accept     = bus.cpu_req && ready;

  // State register
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !bus.cpu_we && !lookup_hit) state_d = MISS;
      MISS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: BRAM port is driven straight from the CPU request while idle
  always_comb begin
    ready  = (state_q == IDLE) && !bus.flush;
    mem_en = 1'b0;
    mem_we = 1'b0;
    if (state_q == IDLE && bus.cpu_req && ready) begin
      mem_en = bus.cpu_we || !lookup_hit;
      mem_we = bus.cpu_we;
    end
  end

  assign bus.cpu_ready  = ready;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = bus.cpu_addr;
  assign bus.mem_wdata  = bus.cpu_wdata;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.hit        = hit_q;

  // Control state and read response; flush only takes effect once back in IDLE
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (state_q == MISS) begin
        valid_q[miss_idx_q] <= 1'b1;
        rdata_q             <= bus.mem_rdata;
        rvalid_q            <= 1'b1;
      end else if (bus.flush) begin
        valid_q <= '0;
      end else if (accept) begin
        hit_q <= lookup_hit;
        if (!bus.cpu_we) begin
          if (lookup_hit) begin
            rdata_q  <= data_q[idx];
            rvalid_q <= 1'b1;
          end else begin
            miss_idx_q <= idx;
            miss_tag_q <= tag_f;
          end
        end
      end
    end
  end

  // Tag/data arrays carry no reset; a reset during MISS forces IDLE so no fill lands
  always_ff @(posedge clk_100) begin
    if (state_q == MISS) begin
      data_q[miss_idx_q] <= bus.mem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (accept && bus.cpu_we && lookup_hit) begin
      data_q[idx] <= bus.cpu_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a shadow memory plus a per-index "cached address"
// table predicts read data, hit/miss, latency and BRAM traffic.
module tb_data_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_if #(.DATA_W(16)) bus ();

  data_cache #(.INDEX_BITS(4), .DATA_W(16)) dut (
    .clk_100 (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  logic [15:0] bram   [65536];
  logic [15:0] shadow [65536];
  int          line_addr [16];
  int          n_vec = 0;
  int          n_err = 0;

  // BRAM port B: write on enable+we, read data one cycle after enable without we
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= bram[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [15:0] a);
    return line_addr[a[3:0]] == int'(a);
  endfunction

  task automatic model_invalidate();
    for (int i = 0; i < 16; i++) line_addr[i] = -1;
  endtask

  // All tasks start and end at a falling edge
  task automatic do_read(input logic [15:0] a);
    bit exp_hit;
    exp_hit = model_hit(a);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    #1;
    check_eq("rd_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("rd_mem_en", 32'(bus.mem_en), 32'(!exp_hit));
    check_eq("rd_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check_eq("rd_hit", 32'(bus.hit), 32'(exp_hit));
    if (exp_hit) begin
      check_eq("rd_hit_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      check_eq("rd_hit_rdata", 32'(bus.cpu_rdata), 32'(shadow[a]));
      bus.cpu_req = 1'b0;
    end else begin
      check_eq("rd_miss_rvalid_early", 32'(bus.cpu_rvalid), 32'd0);
      check_eq("rd_miss_ready", 32'(bus.cpu_ready), 32'd0);
      check_eq("rd_miss_mem_en", 32'(bus.mem_en), 32'd0);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check_eq("rd_miss_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      check_eq("rd_miss_rdata", 32'(bus.cpu_rdata), 32'(shadow[a]));
      check_eq("rd_miss_hitflag", 32'(bus.hit), 32'd0);
      line_addr[a[3:0]] = int'(a);
    end
    @(negedge clk);
    check_eq("rd_pulse_end", 32'(bus.cpu_rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bit exp_hit;
    exp_hit = model_hit(a);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    #1;
    check_eq("wr_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("wr_mem_en", 32'(bus.mem_en), 32'd1);
    check_eq("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("wr_mem_addr", 32'(bus.mem_addr), 32'(a));
    check_eq("wr_mem_wdata", 32'(bus.mem_wdata), 32'(d));
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    check_eq("wr_hit", 32'(bus.hit), 32'(exp_hit));
    check_eq("wr_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    shadow[a] = d;
  endtask

  task automatic do_flush(input logic [15:0] a);
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    #1;
    check_eq("fl_ready", 32'(bus.cpu_ready), 32'd0);
    check_eq("fl_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0; bus.cpu_req = 1'b0;
    check_eq("fl_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    model_invalidate();
  endtask

  task automatic flush_during_miss(input logic [15:0] a);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    #1;
    check_eq("fm_mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.flush = 1'b1;
    #1;
    check_eq("fm_ready_miss", 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    check_eq("fm_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check_eq("fm_rdata", 32'(bus.cpu_rdata), 32'(shadow[a]));
    check_eq("fm_ready_flush", 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("fm_pulse_end", 32'(bus.cpu_rvalid), 32'd0);
    model_invalidate();
  endtask

  task automatic reset_during_miss(input logic [15:0] a);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check_eq("rm_in_miss", 32'(bus.cpu_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rm_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check_eq("rm_hit", 32'(bus.hit), 32'd0);
    check_eq("rm_rdata", 32'(bus.cpu_rdata), 32'd0);
    check_eq("rm_ready", 32'(bus.cpu_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check_eq("rm_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rm_no_rvalid_after", 32'(bus.cpu_rvalid), 32'd0);
    model_invalidate();
  endtask

  // Back-to-back accepted accesses: two hit reads then a hit write on consecutive cycles
  task automatic burst(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    @(negedge clk);
    check_eq("bb_rvalid_a", 32'(bus.cpu_rvalid), 32'd1);
    check_eq("bb_rdata_a", 32'(bus.cpu_rdata), 32'(shadow[a]));
    bus.cpu_addr = b;
    @(negedge clk);
    check_eq("bb_rvalid_b", 32'(bus.cpu_rvalid), 32'd1);
    check_eq("bb_rdata_b", 32'(bus.cpu_rdata), 32'(shadow[b]));
    bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    check_eq("bb_wr_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check_eq("bb_wr_hit", 32'(bus.hit), 32'd1);
    shadow[a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] tags [4];
    logic [15:0] a;
    int unsigned r;
    tags[0] = 12'h000; tags[1] = 12'h001; tags[2] = 12'h7A3; tags[3] = 12'hFFF;

    for (int i = 0; i < 65536; i++) begin
      bram[i]   = 16'(i * 37 + 11);
      shadow[i] = bram[i];
    end
    bram[16'h0012]   = 16'hBEEF;
    shadow[16'h0012] = 16'hBEEF;
    model_invalidate();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_hit", 32'(bus.hit), 32'd0);
    check_eq("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    check_eq("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check_eq("rst_ready", 32'(bus.cpu_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(16'h0012);
    do_read(16'h0012);
    do_write(16'h0012, 16'h1234);
    do_read(16'h0012);
    do_read(16'h0022);
    do_read(16'h0012);
    do_flush(16'h0022);
    do_read(16'h0022);
    reset_during_miss(16'h0045);
    do_read(16'h0045);
    do_write(16'h0077, 16'hA5A5);
    do_read(16'h0077);
    flush_during_miss(16'h0037);
    do_read(16'h0037);
    do_read(16'h0101);
    do_read(16'h0202);
    burst(16'h0101, 16'h0202, 16'h5555);
    do_read(16'h0101);

    for (int n = 0; n < 400; n++) begin
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      r = $urandom_range(0, 99);
      if (r < 55)      do_read(a);
      else if (r < 92) do_write(a, 16'($urandom));
      else             do_flush(a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
